// File: rtl/toss_seq_gen.sv
// Serial coin-toss stream generator with a built-in Moore model of the
// three-heads (non-overlapping) detector for scoreboarding.
module toss_seq_gen #(
  parameter int unsigned LEN_W = 4,
  parameter logic [7:0]  SEED  = 8'hA5,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [LEN_W-1:0] req_len,
  input  logic             req_mode,
  output logic             req_ready,
  output logic             toss,
  output logic             toss_valid,
  output logic             busy,
  output logic             done,
  output logic             exp_out,
  output logic [CNT_W-1:0] hit_count
);

  localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADS,
    S_RAND,
    S_TAIL,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [7:0]       lfsr_q, lfsr_d;
  logic [1:0]       h_q, h_d;
  logic [CNT_W-1:0] hit_q, hit_d;
  logic             toss_q, toss_d;
  logic             toss_valid_q, toss_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
  logic             exp_q, exp_d;
  logic             fb;

  assign fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

  // Next-state, detector model and registered-output decode.
  // Outputs are decoded from the next state so they are flop outputs that
  // line up with the state they describe.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    lfsr_d  = lfsr_q;
    h_d     = h_q;
    hit_d   = hit_q;

    // Detector model consumes the toss currently on the output.
    if (toss_valid_q) begin
      if (toss_q) begin
        h_d = (h_q == 2'd3) ? 2'd1 : h_q + 2'd1;
        if (h_d == 2'd3 && hit_q != '1) begin
          hit_d = hit_q + CNT_W'(1);
        end
      end else begin
        h_d = '0;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          rem_d = req_len;
          hit_d = '0;
          h_d   = '0;
          if (req_len == '0) begin
            state_d = S_TAIL;
          end else if (req_mode) begin
            state_d = S_RAND;
          end else begin
            state_d = S_HEADS;
          end
        end
      end
      S_HEADS: begin
        rem_d = rem_q - LEN_W'(1);
        if (rem_q == LEN_W'(1)) state_d = S_TAIL;
      end
      S_RAND: begin
        lfsr_d = {lfsr_q[6:0], fb};
        rem_d  = rem_q - LEN_W'(1);
        if (rem_q == LEN_W'(1)) state_d = S_TAIL;
      end
      S_TAIL:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    toss_valid_d = (state_d == S_HEADS) || (state_d == S_RAND) || (state_d == S_TAIL);
    busy_d       = (state_d != S_IDLE);
    ready_d      = (state_d == S_IDLE);
    done_d       = (state_d == S_DONE);
    exp_d        = (h_d == 2'd3);
    // In RAND the shown bit is the MSB of the LFSR value held during that cycle.
    toss_d       = (state_d == S_HEADS) ? 1'b1 :
                   (state_d == S_RAND)  ? lfsr_d[7] : 1'b0;
  end

  // State, datapath and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rem_q        <= '0;
      lfsr_q       <= SEED_EFF;
      h_q          <= '0;
      hit_q        <= '0;
      toss_q       <= 1'b0;
      toss_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ready_q      <= 1'b1;
      exp_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      lfsr_q       <= lfsr_d;
      h_q          <= h_d;
      hit_q        <= hit_d;
      toss_q       <= toss_d;
      toss_valid_q <= toss_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      ready_q      <= ready_d;
      exp_q        <= exp_d;
    end
  end

  assign req_ready  = ready_q;
  assign toss       = toss_q;
  assign toss_valid = toss_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign exp_out    = exp_q;
  assign hit_count  = hit_q;

endmodule

// File: tb/tb_toss_seq_gen.sv
// Scoreboard bench for toss_seq_gen: the driver pushes expected per-cycle
// responses, a negedge monitor pops and compares them.
module tb_toss_seq_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_valid = 1'b0;
  logic [3:0] req_len = '0;
  logic       req_mode = 1'b0;
  logic       req_ready, toss, toss_valid, busy, done, exp_out;
  logic [7:0] hit_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  typedef struct {
    bit toss;
    bit expo;
    int hits;
    int cyc;
  } ent_t;

  ent_t expq[$];
  ent_t doneq[$];
  logic [7:0] lfsr_m;

  toss_seq_gen #(.LEN_W(4), .SEED(8'hA5), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_len(req_len),
    .req_mode(req_mode), .req_ready(req_ready), .toss(toss),
    .toss_valid(toss_valid), .busy(busy), .done(done),
    .exp_out(exp_out), .hit_count(hit_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // x^8+x^6+x^5+x^4+1 : feedback is the parity of bits 7,5,4,3.
  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], ^(l & 8'hB8)};
  endfunction

  // Reference: bit list, then detector outputs from the running head count.
  task automatic model_push(input bit mode, input int len, input int c0);
    bit   bits[$];
    int   run = 0;
    int   hits = 0;
    ent_t e;
    for (int i = 0; i < len; i++) begin
      if (mode) begin
        bits.push_back(lfsr_m[7]);
        lfsr_m = lfsr_next(lfsr_m);
      end else begin
        bits.push_back(1'b1);
      end
    end
    bits.push_back(1'b0);
    for (int j = 0; j < bits.size(); j++) begin
      e.toss = bits[j];
      e.expo = (run != 0) && (run % 3 == 0);
      e.hits = hits;
      e.cyc  = c0 + j;
      expq.push_back(e);
      if (bits[j]) begin
        run++;
        if (run % 3 == 0) hits++;
      end else begin
        run = 0;
      end
    end
    e.toss = 1'b0;
    e.expo = 1'b0;
    e.hits = (hits > 255) ? 255 : hits;
    e.cyc  = c0 + len + 1;
    doneq.push_back(e);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (req_ready === 1'b1 && expq.size() == 0 && doneq.size() == 0) return;
    end
    checks++;
    failures++;
    $display("FAIL idle_timeout: req_ready=%b pending=%0d", req_ready, expq.size() + doneq.size());
  endtask

  task automatic issue(input bit mode, input int len, input bit pulse);
    int c0;
    wait_idle();
    req_mode  = mode;
    req_len   = 4'(len);
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    c0 = cyc;
    model_push(mode, len, c0);
    if (pulse) begin
      @(negedge clk);
      req_len   = 4'($urandom);
      req_mode  = 1'($urandom);
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_toss"}, 32'(toss), 32'd0);
    chk({tag, "_toss_valid"}, 32'(toss_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_exp_out"}, 32'(exp_out), 32'd0);
    chk({tag, "_hit_count"}, 32'(hit_count), 32'd0);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
  endtask

  // Monitor: compares every toss_valid and done cycle against the scoreboard.
  always @(negedge clk) begin
    if (mon_en && rst === 1'b0) begin
      bit   exp_busy;
      ent_t e;
      exp_busy = (expq.size() != 0) || (doneq.size() != 0);
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("req_ready", 32'(req_ready), 32'(!exp_busy));
      if (toss_valid === 1'b1) begin
        if (expq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_toss: toss_valid=1 expected 0 (cycle %0d)", cyc);
        end else begin
          e = expq.pop_front();
          chk("toss", 32'(toss), 32'(e.toss));
          chk("exp_out", 32'(exp_out), 32'(e.expo));
          chk("hit_count", 32'(hit_count), 32'(e.hits));
          chk("toss_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      if (done === 1'b1) begin
        if (doneq.size() == 0 || expq.size() != 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: done=1 expected 0 (cycle %0d)", cyc);
        end else begin
          e = doneq.pop_front();
          chk("done_cycle", 32'(cyc), 32'(e.cyc));
          chk("done_hit_count", 32'(hit_count), 32'(e.hits));
          chk("done_exp_out", 32'(exp_out), 32'd0);
          chk("done_toss_valid", 32'(toss_valid), 32'd0);
        end
      end
    end
  end

  initial begin
    int c0;
    // Asynchronous reset asserted mid-cycle.
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1 chk_reset_outputs("rst");
    lfsr_m = 8'hA5;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;

    // Directed sequences.
    issue(1'b0, 3, 1'b0);
    issue(1'b0, 7, 1'b0);
    issue(1'b0, 0, 1'b0);
    issue(1'b0, 15, 1'b0);
    issue(1'b1, 8, 1'b0);
    issue(1'b1, 8, 1'b1);

    // Reset after two heads of a len=5 run.
    wait_idle();
    req_mode  = 1'b0;
    req_len   = 4'd5;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    c0 = cyc;
    model_push(1'b0, 5, c0);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("abort");
    expq.delete();
    doneq.delete();
    lfsr_m = 8'hA5;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    issue(1'b0, 3, 1'b0);
    issue(1'b1, 8, 1'b0);

    // Randomized requests.
    for (int k = 0; k < 20; k++) begin
      issue(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    wait_idle();
    repeat (3) @(negedge clk);
    chk("final_pending", 32'(expq.size() + doneq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
